fp_vector_checker: RTL

- Synthesizable, parametrised stimulus/compare engine for the floating-point unit; generalises the single-format, lock-step file-driven check to XLEN 32/64, multiple outstanding operations and selectable stop-on-fail or count-all mode.
- Accepts test vectors over a valid/ready stream and issues operands to the FPU.
- Queues expected result/flags in an in-order FIFO and compares each FPU response against its queued entry, with canonical-NaN masking.
- Reports pass/fail counters and captures the first mismatch.

---
 rtl/fp_vector_checker.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/fp_vector_checker.sv
// fp_vector_checker: issues FPU test vectors from a valid/ready stream, queues expected
// results in order and compares each FPU response (canonical-NaN aware), capturing the first miss.
module fp_vector_checker #(
   parameter int XLEN         = 32,
   parameter int DEPTH        = 4,
   parameter int CNTW         = 16,
   parameter bit STOP_ON_FAIL = 1'b1
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            start_i,
   input  logic            vec_valid_i,
   output logic            vec_ready_o,
   input  logic [XLEN-1:0] vec_data1_i,
   input  logic [XLEN-1:0] vec_data2_i,
   input  logic [XLEN-1:0] vec_data3_i,
   input  logic [2:0]      vec_rm_i,
   input  logic [XLEN-1:0] vec_result_i,
   input  logic [4:0]      vec_flags_i,
   input  logic            vec_nan_mask_i,
   input  logic            vec_last_i,
   output logic            fpu_valid_o,
   input  logic            fpu_ready_i,
   output logic [XLEN-1:0] fpu_data1_o,
   output logic [XLEN-1:0] fpu_data2_o,
   output logic [XLEN-1:0] fpu_data3_o,
   output logic [2:0]      fpu_rm_o,
   input  logic            rsp_valid_i,
   input  logic [XLEN-1:0] rsp_result_i,
   input  logic [4:0]      rsp_flags_i,
   output logic            busy_o,
   output logic            done_o,
   output logic            failed_o,
   output logic            proto_err_o,
   output logic [CNTW-1:0] pass_count_o,
   output logic [CNTW-1:0] fail_count_o,
   output logic [CNTW-1:0] fail_index_o,
   output logic [XLEN-1:0] fail_ref_result_o,
   output logic [XLEN-1:0] fail_calc_result_o,
   output logic [4:0]      fail_ref_flags_o,
   output logic [4:0]      fail_calc_flags_o
);
   typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE, S_FAIL} state_t;
   localparam int AW = $clog2(DEPTH);
   // The canonical NaN pattern is exactly the exponent + mantissa-MSB field, so it doubles as the mask.
   localparam logic [XLEN-1:0] CANON = (XLEN == 64) ? XLEN'(64'h7FF8_0000_0000_0000) : XLEN'(32'h7FC0_0000);

   state_t state_q, state_d;
   logic [AW:0] wptr_q, rptr_q, count;
   logic full, empty, push, pop, clr, cmp, masked, mism;
   logic [XLEN-1:0] res_mem_q [DEPTH];
   logic [4:0] flg_mem_q [DEPTH];
   logic msk_mem_q [DEPTH];
   logic [CNTW-1:0] idx_mem_q [DEPTH];
   logic [XLEN-1:0] h_res;
   logic [4:0] h_flg;
   logic h_msk;
   logic [CNTW-1:0] h_idx;
   logic [CNTW-1:0] idx_q, pass_q, fail_q, fidx_q;
   logic failed_q, perr_q;
   logic [XLEN-1:0] fref_q, fcalc_q;
   logic [4:0] frflg_q, fcflg_q;

   assign fpu_data1_o = vec_data1_i;
   assign fpu_data2_o = vec_data2_i;
   assign fpu_data3_o = vec_data3_i;
   assign fpu_rm_o = vec_rm_i;
   assign h_res = res_mem_q[rptr_q[AW-1:0]];
   assign h_flg = flg_mem_q[rptr_q[AW-1:0]];
   assign h_msk = msk_mem_q[rptr_q[AW-1:0]];
   assign h_idx = idx_mem_q[rptr_q[AW-1:0]];

   always_comb begin
      count = wptr_q - rptr_q;
      full = count == (AW+1)'(DEPTH);
      empty = count == '0;
      push = vec_valid_i && vec_ready_o;
      pop = rsp_valid_i && !empty;
      clr = start_i && !busy_o;
      cmp = pop && busy_o;
      masked = h_msk && (rsp_result_i == CANON);
      mism = (|((rsp_result_i ^ h_res) & (masked ? CANON : '1))) || (rsp_flags_i != h_flg);
   end

   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) state_q <= S_IDLE;
      else state_q <= state_d;

   always_comb begin
      state_d = state_q;
      if (clr) state_d = S_RUN;
      else if (cmp && mism && STOP_ON_FAIL) state_d = S_FAIL;
      else if (state_q == S_RUN && push && vec_last_i) state_d = S_DRAIN;
      else if (state_q == S_DRAIN && empty && !rsp_valid_i) state_d = S_DONE;
   end

   always_comb begin
      busy_o = (state_q == S_RUN) || (state_q == S_DRAIN);
      done_o = state_q == S_DONE;
      vec_ready_o = (state_q == S_RUN) && fpu_ready_i && !full;
      fpu_valid_o = (state_q == S_RUN) && vec_valid_i && !full;
   end

   always_ff @(posedge clk_i)
      if (push) begin
         res_mem_q[wptr_q[AW-1:0]] <= vec_result_i;
         flg_mem_q[wptr_q[AW-1:0]] <= vec_flags_i;
         msk_mem_q[wptr_q[AW-1:0]] <= vec_nan_mask_i;
         idx_mem_q[wptr_q[AW-1:0]] <= idx_q;
      end

   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni || clr) begin
         wptr_q <= '0;
         rptr_q <= '0;
         idx_q <= '0;
         pass_q <= '0;
         fail_q <= '0;
         fidx_q <= '0;
         failed_q <= 1'b0;
         perr_q <= 1'b0;
         fref_q <= '0;
         fcalc_q <= '0;
         frflg_q <= '0;
         fcflg_q <= '0;
      end else begin
         if (push) wptr_q <= wptr_q + (AW+1)'(1);
         if (push) idx_q <= idx_q + CNTW'(1);
         if (pop) rptr_q <= rptr_q + (AW+1)'(1);
         if (rsp_valid_i && empty) perr_q <= 1'b1;
         if (cmp && !mism && pass_q != '1) pass_q <= pass_q + CNTW'(1);
         if (cmp && mism && fail_q != '1) fail_q <= fail_q + CNTW'(1);
         if (cmp && mism) failed_q <= 1'b1;
         if (cmp && mism && !failed_q) begin
            fidx_q <= h_idx;
            fref_q <= h_res;
            fcalc_q <= rsp_result_i;
            frflg_q <= h_flg;
            fcflg_q <= rsp_flags_i;
         end
      end

   assign failed_o = failed_q;
   assign proto_err_o = perr_q;
   assign pass_count_o = pass_q;
   assign fail_count_o = fail_q;
   assign fail_index_o = fidx_q;
   assign fail_ref_result_o = fref_q;
   assign fail_calc_result_o = fcalc_q;
   assign fail_ref_flags_o = frflg_q;
   assign fail_calc_flags_o = fcflg_q;
endmodule
